// File: rtl/rv32i_writeback.sv
// rv32i_writeback: RV32I writeback stage driving the register file write port, with load formatting and retire counting
module rv32i_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] alu_result_i,
  input  logic        is_load_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wr,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd,
  output logic        misaligned_o,
  output logic [63:0] instret_o
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t      state_q, state_d;
  logic        wr_q, wr_d, mis_q, mis_d;
  logic [4:0]  rd_addr_q, rd_addr_d, ld_addr_q, ld_addr_d;
  logic [31:0] rd_q, rd_d;
  logic [63:0] instret_q, instret_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lsb_q, lsb_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;
  logic        ld_legal;
  assign byte_sel = 8'(mem_rdata >> {lsb_q, 3'b000});
  assign half_sel = lsb_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ld_legal = (f3_q[1:0] == 2'b00) || (f3_q[1:0] == 2'b01 && !lsb_q[0]) || (f3_q == 3'b010 && lsb_q == 2'b00);
  assign ld_data  = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_sel[7]}}, byte_sel}
                  : f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_sel[15]}}, half_sel}
                  : mem_rdata;
  always_comb begin
    state_d   = state_q;
    wr_d      = 1'b0;
    mis_d     = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_d      = rd_q;
    instret_d = instret_q;
    ld_addr_d = ld_addr_q;
    f3_d      = f3_q;
    lsb_d     = lsb_q;
    if (state_q == IDLE && valid_i) begin
      if (is_load_i) begin
        state_d   = WAIT_LOAD;
        ld_addr_d = rd_addr_i;
        f3_d      = funct3_i;
        lsb_d     = addr_lsb_i;
      end else begin
        rd_addr_d = rd_addr_i;
        rd_d      = alu_result_i;
        wr_d      = |rd_addr_i;
        instret_d = instret_q + 64'd1;
      end
    end else if (state_q == WAIT_LOAD && mem_ack) begin
      state_d = IDLE;
      if (ld_legal) begin
        rd_addr_d = ld_addr_q;
        rd_d      = ld_data;
        wr_d      = |ld_addr_q;
        instret_d = instret_q + 64'd1;
      end else begin
        mis_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      mis_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_q      <= '0;
      instret_q <= '0;
      ld_addr_q <= '0;
      f3_q      <= '0;
      lsb_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      mis_q     <= mis_d;
      rd_addr_q <= rd_addr_d;
      rd_q      <= rd_d;
      instret_q <= instret_d;
      ld_addr_q <= ld_addr_d;
      f3_q      <= f3_d;
      lsb_q     <= lsb_d;
    end
  end
  assign ready_o      = state_q == IDLE;
  assign wr           = wr_q;
  assign rd_addr      = rd_addr_q;
  assign rd           = rd_q;
  assign misaligned_o = mis_q;
  assign instret_o    = instret_q;
endmodule

// File: doc/rv32i_writeback.md
# rv32i_writeback

Writeback stage for the RV32I core: the producer side of the 32-entry base register file's write port (rd_addr / rd / wr). Accepts one retiring instruction per handshake, either an ALU result, committed next cycle, or a load, held until the data memory acknowledges. Load data is aligned and sign/zero-extended before commit. The block suppresses writes to x0, flags misaligned or illegal loads, and counts retired instructions.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  retiring instruction present this cycle
- ready_o  out  1  block can accept; combinational, high iff state is IDLE
- rd_addr_i  in  5  destination register
- alu_result_i  in  32  result for non-load instructions
- is_load_i  in  1  instruction is a load
- funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- addr_lsb_i  in  2  byte offset of the load address
- mem_rdata  in  32  data memory read word (aligned word)
- mem_ack  in  1  data memory read complete; sampled only in WAIT_LOAD
- wr  out  1  register file write enable, one-cycle pulse
- rd_addr  out  5  register file write address
- rd  out  32  register file write data
- misaligned_o  out  1  one-cycle pulse: load discarded (misaligned or illegal funct3)
- instret_o  out  64  retired-instruction count

## Operation
- FSM states: IDLE, WAIT_LOAD. Reset state is IDLE.
- Accept is valid_i && ready_o at a rising edge.
- IDLE, accepted non-load:
  - Register rd_addr_i and alu_result_i onto rd_addr/rd.
  - wr = (rd_addr_i != 0).
  - instret_o += 1.
  - Stay in IDLE.
- IDLE, accepted load:
  - Capture rd_addr_i, funct3_i, addr_lsb_i.
  - Go to WAIT_LOAD.
  - wr = 0.
- WAIT_LOAD, mem_ack low: hold; wr = 0; valid_i is ignored because ready_o = 0.
- WAIT_LOAD, mem_ack high:
  - Return to IDLE.
  - If the load is legal: rd = formatted data, wr = (captured rd_addr != 0), instret_o += 1.
  - Otherwise: wr = 0, misaligned_o = 1, instret unchanged.
- Load formatting, where L = captured lsb:
  - LB/LBU select byte mem_rdata[8L+7:8L].
  - LH/LHU select half mem_rdata[16·L[1]+15:16·L[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes mem_rdata unchanged.
- Discard conditions:
  - LH/LHU with L[0] = 1.
  - LW with L != 0.
  - funct3 ∈ {011, 110, 111}.
- Retirement counting: x0-destination instructions still retire (instret increments) but never assert wr.
- instret_o is a 64-bit counter that wraps from 2^64−1 to 0.
- mem_ack while in IDLE is ignored.
- Reset values: state IDLE, wr 0, rd_addr 0, rd 0, misaligned_o 0, instret_o 0. ready_o is therefore 1 after reset.
- Reset asserted while in WAIT_LOAD: the pending load is dropped with no write and no count. A later mem_ack arriving in IDLE is ignored.

## Timing
- All outputs except ready_o are registered.
- wr, rd_addr, rd and misaligned_o are valid for exactly the cycle following the commit edge. The register file captures the write on the next edge.
- ALU instruction accepted at edge k: wr is high during cycle k→k+1 and the register file is written at edge k+1. Back-to-back ALU accepts give one write per cycle.
- Load accepted at edge k: earliest mem_ack sample is edge k+1, earliest write is at edge k+2.
- A load acknowledged at edge m:
  - ready_o returns high during cycle m→m+1.
  - A new instruction may be accepted at edge m+1.
- wr deasserts automatically after one cycle. rd and rd_addr hold their last values when wr = 0.

## Test plan
- Reset, then accept ALU op rd_addr_i=5, alu_result_i=0xDEADBEEF → one cycle later wr=1, rd_addr=5, rd=0xDEADBEEF; instret_o=1; next cycle wr=0.
- ALU op rd_addr_i=0, result 0x1234 → wr stays 0; instret_o increments.
- LB with lsb=3, mem_rdata=0x80FF_0000, mem_ack 3 cycles after accept → ready_o low for 3 cycles; then wr=1, rd=0xFFFFFF80. Repeat as LBU → rd=0x00000080.
- LHU lsb=2, mem_rdata=0xBEEF_1234 → rd=0x0000BEEF. LH lsb=1 → misaligned_o pulse, wr=0, instret_o unchanged.
- Load accepted, rst asserted before mem_ack, then mem_ack pulsed → all outputs at reset values; no write; instret_o=0.
- 10 back-to-back ALU ops followed by 1 LW (lsb=0, rdata=0xCAFEF00D) → 10 consecutive wr pulses, then LW commit rd=0xCAFEF00D; instret_o=11.
